// File: rtl/blink_scheduler_if.sv
// Request / blinker-handshake bundle between the lock controller, blink_scheduler and blinker.
interface blink_scheduler_if;
    logic req_error;
    logic req_success;
    logic blink_done;
    logic blink_start;
    logic blink_type;
    logic busy;
    logic abort;

    modport master (
        output req_error, req_success, blink_done,
        input  blink_start, blink_type, busy, abort
    );

    modport slave (
        input  req_error, req_success, blink_done,
        output blink_start, blink_type, busy, abort
    );
endinterface

// File: rtl/blink_scheduler.sv
// Sequences error/success LED patterns on a single blinker with a dark gap between patterns.
// Optional RUN watchdog with abort pulse: define BLINK_TIMEOUT_EN.
module blink_scheduler #(
    parameter int unsigned ARM_CYCLES     = 2,
    parameter int unsigned GAP_CYCLES     = 1200000,
    parameter int unsigned TIMEOUT_CYCLES = 120000000
) (
    input  logic             hwclk,
    input  logic             rst,
    blink_scheduler_if.slave bus
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
`ifdef BLINK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    // Elaboration-time parameter sanity checks
    if (ARM_CYCLES < 1 || ARM_CYCLES > 255) begin : g_bad_arm
        $error("blink_scheduler: ARM_CYCLES out of range");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("blink_scheduler: GAP_CYCLES out of range");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_to
        $error("blink_scheduler: TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pend_err, pend_err_n;
    logic             pend_ok, pend_ok_n;
    logic             start_q, start_n;
    logic             type_q, type_n;
    logic             busy_q, busy_n;
    logic             abort_q, abort_n;
    logic             grant_err, grant_ok;

    // State and output registers
    always_ff @(posedge hwclk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_err <= 1'b0;
            pend_ok  <= 1'b0;
            start_q  <= 1'b0;
            type_q   <= 1'b0;
            busy_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pend_err <= pend_err_n;
            pend_ok  <= pend_ok_n;
            start_q  <= start_n;
            type_q   <= type_n;
            busy_q   <= busy_n;
            abort_q  <= abort_n;
        end
    end

    // Next-state, counter, arbitration and output decode
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        type_n    = type_q;
        abort_n   = 1'b0;
        grant_err = 1'b0;
        grant_ok  = 1'b0;

        case (state)
            IDLE: begin
                if (pend_err) begin
                    grant_err = 1'b1;
                    type_n    = 1'b0;
                    state_n   = ARM;
                end else if (pend_ok) begin
                    grant_ok  = 1'b1;
                    type_n    = 1'b1;
                    state_n   = ARM;
                end
            end
            ARM: begin
                // blink_done is deliberately ignored here: it may still be high from the last pattern
                if (cnt == ARM_LAST) state_n = RUN;
                else                 cnt_n   = cnt + CNT_W'(1);
            end
            RUN: begin
                if (bus.blink_done) begin
                    state_n = GAP;
                end
`ifdef BLINK_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    state_n = GAP;
                    abort_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
`endif
            end
            GAP: begin
                if (cnt == GAP_LAST) state_n = IDLE;
                else                 cnt_n   = cnt + CNT_W'(1);
            end
            default: state_n = IDLE;
        endcase

        if (state_n != state) cnt_n = '0;

        // A same-type request on the grant edge re-arms the flag (set wins)
        pend_err_n = (pend_err & ~grant_err) | bus.req_error;
        pend_ok_n  = (pend_ok  & ~grant_ok)  | bus.req_success;

        start_n = (state_n == ARM) || (state_n == RUN);
        busy_n  = (state != IDLE) || pend_err || pend_ok;
    end

    assign bus.blink_start = start_q;
    assign bus.blink_type  = type_q;
    assign bus.busy        = busy_q;
    assign bus.abort       = abort_q;

endmodule

// File: tb/tb_blink_scheduler.sv
// Directed self-checking bench for blink_scheduler (ARM=2, GAP=4, TIMEOUT=20).
module tb_blink_scheduler;

    logic hwclk;
    logic rst;
    int   total;
    int   bad;

    int   w_rises, w_aborts, w_abort_at, w_fall_at, w_high, w_busy;
    int   w_rise_at [4];
    int   w_type    [4];
    int   w_len     [4];

    blink_scheduler_if bus ();

    blink_scheduler #(
        .ARM_CYCLES     (2),
        .GAP_CYCLES     (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .hwclk (hwclk),
        .rst   (rst),
        .bus   (bus)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    // Observe n edges, recording start rises, high lengths, falls, aborts and busy cycles
    task automatic watch(input int n);
        logic prev;
        prev       = bus.blink_start;
        w_rises    = 0;
        w_aborts   = 0;
        w_abort_at = -1;
        w_fall_at  = -1;
        w_high     = 0;
        w_busy     = 0;
        for (int i = 0; i < 4; i++) begin
            w_rise_at[i] = -1;
            w_type[i]    = -1;
            w_len[i]     = 0;
        end
        for (int c = 1; c <= n; c++) begin
            tick();
            if (bus.blink_start && !prev) begin
                if (w_rises < 4) begin
                    w_rise_at[w_rises] = c;
                    w_type[w_rises]    = int'(bus.blink_type);
                end
                w_rises++;
            end
            if (bus.blink_start) begin
                w_high++;
                if (w_rises >= 1 && w_rises <= 4) w_len[w_rises-1]++;
            end
            if (!bus.blink_start && prev && w_fall_at < 0) w_fall_at = c;
            if (bus.abort) begin
                w_aborts++;
                if (w_abort_at < 0) w_abort_at = c;
            end
            if (bus.busy) w_busy++;
            prev = bus.blink_start;
        end
    endtask

    initial begin
        total           = 0;
        bad             = 0;
        rst             = 1'b1;
        bus.req_error   = 1'b0;
        bus.req_success = 1'b0;
        bus.blink_done  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_start", 32'(bus.blink_start), 0);
        check("rst_type",  32'(bus.blink_type),  0);
        check("rst_busy",  32'(bus.busy),        0);
        check("rst_abort", 32'(bus.abort),       0);

        // Single success request: 2-cycle latency, done drops start, busy trails GAP by one
        bus.req_success = 1'b1;
        tick();
        bus.req_success = 1'b0;
        check("t1_busy_lag",  32'(bus.busy),        0);
        check("t1_start_lag", 32'(bus.blink_start), 0);
        tick();
        check("t1_start", 32'(bus.blink_start), 1);
        check("t1_type",  32'(bus.blink_type),  1);
        check("t1_busy",  32'(bus.busy),        1);
        repeat (8) tick();
        check("t1_run_hold", 32'(bus.blink_start), 1);
        bus.blink_done = 1'b1;
        tick();
        check("t1_done_drop", 32'(bus.blink_start), 0);
        bus.blink_done = 1'b0;
        repeat (4) tick();
        check("t1_busy_gap", 32'(bus.busy), 1);
        tick();
        check("t1_busy_end", 32'(bus.busy), 0);

        // Simultaneous requests with stale done held high: error then success, 3-cycle pulses
        bus.blink_done  = 1'b1;
        bus.req_error   = 1'b1;
        bus.req_success = 1'b1;
        tick();
        bus.req_error   = 1'b0;
        bus.req_success = 1'b0;
        watch(24);
        check("t2_rises",   32'(w_rises),      2);
        check("t2_rise0",   32'(w_rise_at[0]), 1);
        check("t2_type0",   32'(w_type[0]),    0);
        check("t2_len0",    32'(w_len[0]),     3);
        check("t2_rise1",   32'(w_rise_at[1]), 9);
        check("t2_type1",   32'(w_type[1]),    1);
        check("t2_len1",    32'(w_len[1]),     3);
        check("t2_low_gap", 32'(w_rise_at[1] - (w_rise_at[0] + w_len[0])), 5);
        check("t2_busy_end", 32'(bus.busy), 0);
        bus.blink_done = 1'b0;

        // Three error requests during RUN merge into one further pattern
        bus.req_error = 1'b1;
        tick();
        bus.req_error = 1'b0;
        repeat (3) tick();
        check("t3_in_run", 32'(bus.blink_start), 1);
        for (int i = 0; i < 3; i++) begin
            bus.req_error = 1'b1;
            tick();
            bus.req_error = 1'b0;
            tick();
        end
        check("t3_not_preempted", 32'(bus.blink_start), 1);
        bus.blink_done = 1'b1;
        tick();
        check("t3_done_drop", 32'(bus.blink_start), 0);
        watch(20);
        check("t3_rises", 32'(w_rises),      1);
        check("t3_rise0", 32'(w_rise_at[0]), 5);
        check("t3_type0", 32'(w_type[0]),    0);
        check("t3_len0",  32'(w_len[0]),     3);
        bus.blink_done = 1'b0;
        check("t3_busy_end", 32'(bus.busy), 0);

        // Reset during RUN with a success pending; request coincident with reset is lost
        bus.req_success = 1'b1;
        tick();
        bus.req_success = 1'b0;
        repeat (3) tick();
        bus.req_success = 1'b1;
        tick();
        bus.req_success = 1'b0;
        check("t4_pre_start", 32'(bus.blink_start), 1);
        check("t4_pre_type",  32'(bus.blink_type),  1);
        rst           = 1'b1;
        bus.req_error = 1'b1;
        tick();
        rst           = 1'b0;
        bus.req_error = 1'b0;
        check("t4_start", 32'(bus.blink_start), 0);
        check("t4_type",  32'(bus.blink_type),  0);
        check("t4_busy",  32'(bus.busy),        0);
        check("t4_abort", 32'(bus.abort),       0);
        watch(20);
        check("t4_no_rise", 32'(w_rises), 0);
        check("t4_no_busy", 32'(w_busy),  0);

        // RUN with done never arriving
        bus.req_error = 1'b1;
        tick();
        bus.req_error = 1'b0;
`ifdef BLINK_TIMEOUT_EN
        watch(40);
        check("t5_rises",    32'(w_rises),    1);
        check("t5_rise0",    32'(w_rise_at[0]), 1);
        check("t5_aborts",   32'(w_aborts),   1);
        check("t5_abort_at", 32'(w_abort_at), 23);
        check("t5_fall_at",  32'(w_fall_at),  23);
        check("t5_len0",     32'(w_len[0]),   22);
        check("t5_busy_end", 32'(bus.busy),   0);
`else
        watch(1001);
        check("t5_rises",  32'(w_rises),  1);
        check("t5_high",   32'(w_high),   1001);
        check("t5_no_fall", 32'(w_fall_at), 32'hFFFF_FFFF);
        check("t5_aborts", 32'(w_aborts), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_start", 32'(bus.blink_start), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
